// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for an NDIG-digit common-anode 7-segment display.
// Holds a double-buffered BCD frame and presents one digit per slot, with dead time and leading-zero blanking.
module display_scan_ctrl #(
    parameter int NDIG     = 4,
    parameter int PRESCALE = 50000,
    parameter int DEAD     = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Enable,
    input  logic              Load,
    input  logic [4*NDIG-1:0] BcdIn,
    input  logic              BlankLZ,
    output logic [3:0]        BcdOut,
    output logic [NDIG-1:0]   DigSel,
    output logic              FrameTick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DW = (DEAD > 0) ? $clog2(DEAD + 1) : 1;
    localparam int IW = $clog2(NDIG);

    localparam logic [PW-1:0] PCNT_MAX  = PW'(PRESCALE - 1);
    localparam logic [DW-1:0] DCNT_LOAD = DW'(DEAD);
    localparam logic [IW-1:0] IDX_MAX   = IW'(NDIG - 1);

    logic [PW-1:0]      pcnt_q, pcnt_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [DW-1:0]      dcnt_q, dcnt_d;
    logic [4*NDIG-1:0]  pend_q, pend_d;
    logic               pend_v_q, pend_v_d;
    logic [4*NDIG-1:0]  disp_q, disp_d;
    logic               frame_tick_q, frame_tick_d;

    logic               tick;
    logic               dark;
    logic               blank_lz;
    logic               all_zero;
    logic [NDIG-1:0]    zero_from;
    logic [3:0]         cur_digit;

    assign tick = Enable && (pcnt_q == PCNT_MAX);

    always_comb begin
        pcnt_d       = pcnt_q;
        idx_d        = idx_q;
        dcnt_d       = dcnt_q;
        pend_d       = pend_q;
        pend_v_d     = pend_v_q;
        disp_d       = disp_q;
        frame_tick_d = 1'b0;

        if (Enable) begin
            if (tick) begin
                pcnt_d = '0;
                idx_d  = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
                dcnt_d = DCNT_LOAD;
            end else begin
                pcnt_d = pcnt_q + 1'b1;
                if (dcnt_q != '0) begin
                    dcnt_d = dcnt_q - 1'b1;
                end
            end
        end

        if (Load) begin
            pend_d   = BcdIn;
            pend_v_d = 1'b1;
        end

        // A Load coinciding with the swap keeps pend_v set so the new data shows one frame later.
        if (tick && (idx_q == IDX_MAX) && pend_v_q) begin
            disp_d       = pend_q;
            frame_tick_d = 1'b1;
            if (!Load) begin
                pend_v_d = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pcnt_q       <= '0;
            idx_q        <= '0;
            dcnt_q       <= '0;
            pend_q       <= '0;
            pend_v_q     <= 1'b0;
            disp_q       <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            pcnt_q       <= pcnt_d;
            idx_q        <= idx_d;
            dcnt_q       <= dcnt_d;
            pend_q       <= pend_d;
            pend_v_q     <= pend_v_d;
            disp_q       <= disp_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    // zero_from[k] is set when every digit from the top down to k is zero.
    always_comb begin
        all_zero  = 1'b1;
        zero_from = '0;
        for (int k = NDIG - 1; k >= 0; k--) begin
            all_zero     = all_zero && (disp_q[4*k +: 4] == 4'd0);
            zero_from[k] = all_zero;
        end
    end

    assign cur_digit = disp_q[4*int'(idx_q) +: 4];
    assign blank_lz  = BlankLZ && (idx_q != '0) && zero_from[idx_q];
    assign dark      = !Enable || (dcnt_q != '0);

    always_comb begin
        DigSel = '1;
        if (!dark) begin
            DigSel[idx_q] = 1'b0;
        end
    end

    assign BcdOut    = (dark || blank_lz) ? 4'hF : cur_digit;
    assign FrameTick = frame_tick_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed self-checking bench for display_scan_ctrl with NDIG=4, PRESCALE=4, DEAD=1.
// Cycle index n counts clock edges since the last reset; each scan slot spans four values of n.
module tb_display_scan_ctrl;

    logic        Clk;
    logic        Reset;
    logic        Enable;
    logic        Load;
    logic [15:0] BcdIn;
    logic        BlankLZ;
    logic [3:0]  BcdOut;
    logic [3:0]  DigSel;
    logic        FrameTick;

    int n;
    int ft_count;
    int total;
    int passed;

    display_scan_ctrl #(
        .NDIG     (4),
        .PRESCALE (4),
        .DEAD     (1)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Enable    (Enable),
        .Load      (Load),
        .BcdIn     (BcdIn),
        .BlankLZ   (BlankLZ),
        .BcdOut    (BcdOut),
        .DigSel    (DigSel),
        .FrameTick (FrameTick)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic cyc();
        @(posedge Clk);
        #1;
        n++;
        if (FrameTick) ft_count++;
    endtask

    task automatic run_to(input int target);
        while (n < target) cyc();
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        Load  = 1'b0;
        cyc();
        Reset    = 1'b0;
        n        = 0;
        ft_count = 0;
    endtask

    task automatic load_word(input logic [15:0] value);
        Load  = 1'b1;
        BcdIn = value;
        cyc();
        Load  = 1'b0;
    endtask

    task automatic test_reset();
        Enable  = 1'b1;
        BlankLZ = 1'b0;
        do_reset();
        total++;
        if (DigSel !== 4'b1110) $display("[TB] FAIL reset_digsel: got %b want 1110", DigSel);
        else passed++;
        total++;
        if (BcdOut !== 4'h0) $display("[TB] FAIL reset_bcd: got %h want 0", BcdOut);
        else passed++;
        total++;
        if (FrameTick !== 1'b0) $display("[TB] FAIL reset_frametick: got %b want 0", FrameTick);
        else passed++;
    endtask

    task automatic test_scan();
        logic [3:0] exp_sel;
        logic [3:0] exp_bcd;
        int errs;
        errs = 0;
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            cyc();
            if ((i % 4) == 0) begin
                exp_sel = 4'b1111;
                exp_bcd = 4'hF;
            end else begin
                exp_sel = ~(4'b0001 << ((i / 4) % 4));
                exp_bcd = 4'h0;
            end
            if (DigSel !== exp_sel || BcdOut !== exp_bcd) begin
                errs++;
                $display("[TB] FAIL scan n=%0d: got sel=%b bcd=%h want sel=%b bcd=%h",
                         i, DigSel, BcdOut, exp_sel, exp_bcd);
            end
        end
        total++;
        if (errs != 0) $display("[TB] FAIL scan_sequence: got %0d bad cycles want 0", errs);
        else passed++;
        total++;
        if (ft_count !== 0) $display("[TB] FAIL scan_no_frametick: got %0d want 0", ft_count);
        else passed++;
    endtask

    task automatic test_load();
        do_reset();
        run_to(5);
        load_word(16'h1234);
        total++;
        if (BcdOut !== 4'h0) $display("[TB] FAIL load_no_tear_d1: got %h want 0", BcdOut);
        else passed++;
        run_to(13);
        total++;
        if (DigSel !== 4'b0111 || BcdOut !== 4'h0)
            $display("[TB] FAIL load_no_tear_d3: got sel=%b bcd=%h want sel=0111 bcd=0", DigSel, BcdOut);
        else passed++;
        run_to(16);
        total++;
        if (FrameTick !== 1'b1) $display("[TB] FAIL load_frametick: got %b want 1", FrameTick);
        else passed++;
        run_to(17);
        total++;
        if (DigSel !== 4'b1110 || BcdOut !== 4'h4)
            $display("[TB] FAIL load_d0: got sel=%b bcd=%h want sel=1110 bcd=4", DigSel, BcdOut);
        else passed++;
        run_to(21);
        total++;
        if (BcdOut !== 4'h3) $display("[TB] FAIL load_d1: got %h want 3", BcdOut);
        else passed++;
        run_to(25);
        total++;
        if (BcdOut !== 4'h2) $display("[TB] FAIL load_d2: got %h want 2", BcdOut);
        else passed++;
        run_to(29);
        total++;
        if (DigSel !== 4'b0111 || BcdOut !== 4'h1)
            $display("[TB] FAIL load_d3: got sel=%b bcd=%h want sel=0111 bcd=1", DigSel, BcdOut);
        else passed++;
        run_to(34);
        total++;
        if (ft_count !== 1) $display("[TB] FAIL load_tick_count: got %0d want 1", ft_count);
        else passed++;
    endtask

    task automatic test_last_wins();
        do_reset();
        run_to(2);
        load_word(16'h1111);
        run_to(5);
        load_word(16'h2222);
        run_to(17);
        total++;
        if (BcdOut !== 4'h2) $display("[TB] FAIL last_wins_d0: got %h want 2", BcdOut);
        else passed++;
        run_to(29);
        total++;
        if (BcdOut !== 4'h2) $display("[TB] FAIL last_wins_d3: got %h want 2", BcdOut);
        else passed++;
        run_to(34);
        total++;
        if (ft_count !== 1) $display("[TB] FAIL last_wins_ticks: got %0d want 1", ft_count);
        else passed++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        run_to(3);
        load_word(16'h5678);
        run_to(15);
        load_word(16'h4321);
        total++;
        if (FrameTick !== 1'b1) $display("[TB] FAIL b2b_frametick: got %b want 1", FrameTick);
        else passed++;
        run_to(17);
        total++;
        if (BcdOut !== 4'h8) $display("[TB] FAIL b2b_old_d0: got %h want 8", BcdOut);
        else passed++;
        run_to(29);
        total++;
        if (BcdOut !== 4'h5) $display("[TB] FAIL b2b_old_d3: got %h want 5", BcdOut);
        else passed++;
        run_to(33);
        total++;
        if (BcdOut !== 4'h1) $display("[TB] FAIL b2b_new_d0: got %h want 1", BcdOut);
        else passed++;
        run_to(37);
        total++;
        if (BcdOut !== 4'h2) $display("[TB] FAIL b2b_new_d1: got %h want 2", BcdOut);
        else passed++;
        total++;
        if (ft_count !== 2) $display("[TB] FAIL b2b_tick_count: got %0d want 2", ft_count);
        else passed++;
    endtask

    task automatic test_blanking();
        do_reset();
        load_word(16'h0050);
        BlankLZ = 1'b1;
        run_to(17);
        total++;
        if (BcdOut !== 4'h0) $display("[TB] FAIL blank_d0: got %h want 0", BcdOut);
        else passed++;
        run_to(21);
        total++;
        if (BcdOut !== 4'h5) $display("[TB] FAIL blank_d1: got %h want 5", BcdOut);
        else passed++;
        run_to(25);
        total++;
        if (DigSel !== 4'b1011 || BcdOut !== 4'hF)
            $display("[TB] FAIL blank_d2: got sel=%b bcd=%h want sel=1011 bcd=f", DigSel, BcdOut);
        else passed++;
        BlankLZ = 1'b0;
        #1;
        total++;
        if (BcdOut !== 4'h0) $display("[TB] FAIL blank_off_d2: got %h want 0", BcdOut);
        else passed++;
        BlankLZ = 1'b1;
        run_to(29);
        total++;
        if (BcdOut !== 4'hF) $display("[TB] FAIL blank_d3: got %h want f", BcdOut);
        else passed++;
        load_word(16'h0000);
        run_to(33);
        total++;
        if (BcdOut !== 4'h0) $display("[TB] FAIL zero_d0: got %h want 0", BcdOut);
        else passed++;
        run_to(37);
        total++;
        if (BcdOut !== 4'hF) $display("[TB] FAIL zero_d1: got %h want f", BcdOut);
        else passed++;
        BlankLZ = 1'b0;
    endtask

    task automatic test_enable();
        int errs;
        errs = 0;
        do_reset();
        load_word(16'h1234);
        run_to(22);
        Enable = 1'b0;
        #1;
        total++;
        if (DigSel !== 4'b1111 || BcdOut !== 4'hF)
            $display("[TB] FAIL enable_off: got sel=%b bcd=%h want sel=1111 bcd=f", DigSel, BcdOut);
        else passed++;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (DigSel !== 4'b1111 || BcdOut !== 4'hF) errs++;
        end
        total++;
        if (errs != 0) $display("[TB] FAIL enable_dark_hold: got %0d lit cycles want 0", errs);
        else passed++;
        Enable = 1'b1;
        #1;
        total++;
        if (DigSel !== 4'b1101 || BcdOut !== 4'h3)
            $display("[TB] FAIL enable_resume: got sel=%b bcd=%h want sel=1101 bcd=3", DigSel, BcdOut);
        else passed++;
        cyc();
        total++;
        if (DigSel !== 4'b1101) $display("[TB] FAIL enable_same_slot: got %b want 1101", DigSel);
        else passed++;
        cyc();
        total++;
        if (DigSel !== 4'b1111) $display("[TB] FAIL enable_dead: got %b want 1111", DigSel);
        else passed++;
        cyc();
        total++;
        if (DigSel !== 4'b1011 || BcdOut !== 4'h2)
            $display("[TB] FAIL enable_next_slot: got sel=%b bcd=%h want sel=1011 bcd=2", DigSel, BcdOut);
        else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        load_word(16'h1234);
        run_to(17);
        load_word(16'h5555);
        run_to(20);
        total++;
        if (DigSel !== 4'b1111) $display("[TB] FAIL mid_pre_dark: got %b want 1111", DigSel);
        else passed++;
        do_reset();
        total++;
        if (DigSel !== 4'b1110 || BcdOut !== 4'h0 || FrameTick !== 1'b0)
            $display("[TB] FAIL mid_reset: got sel=%b bcd=%h ft=%b want sel=1110 bcd=0 ft=0",
                     DigSel, BcdOut, FrameTick);
        else passed++;
        run_to(17);
        total++;
        if (ft_count !== 0 || BcdOut !== 4'h0)
            $display("[TB] FAIL mid_pend_cleared: got ticks=%0d bcd=%h want ticks=0 bcd=0", ft_count, BcdOut);
        else passed++;
    endtask

    initial begin
        Reset    = 1'b1;
        Enable   = 1'b1;
        Load     = 1'b0;
        BcdIn    = 16'h0000;
        BlankLZ  = 1'b0;
        n        = 0;
        ft_count = 0;
        total    = 0;
        passed   = 0;
        test_reset();
        test_scan();
        test_load();
        test_last_wins();
        test_back_to_back();
        test_blanking();
        test_enable();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Time-multiplexed scan controller for an NDIG-digit common-anode 7-segment display driven by a single shared BCD-to-7-segment decoder. It holds a double-buffered NDIG-digit BCD frame and presents one digit per scan slot on BcdOut, which feeds the decoder. It drives the matching active-low anode select, with dead time between slots against ghosting and optional leading-zero blanking. It sits between the up/down counter datapath (frame source) and the decoder/display pins.

Parameters:
NDIG, 4, number of digits scanned (2..8)
PRESCALE, 50000, Clk cycles per scan slot (>= DEAD+2)
DEAD, 8, cycles at the start of each slot with all anodes off (>= 0)

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  synchronous, active-high reset
Enable  in  1  1 = scanning; 0 = display dark, prescaler frozen
Load  in  1  one-cycle strobe: capture BcdIn into the pending buffer
BcdIn  in  4*NDIG  frame; digit k = BcdIn[4k+3:4k], digit 0 = least significant
BlankLZ  in  1  1 = blank leading zeros
BcdOut  out  4  BCD code to the decoder; 4'hF = blank (decoder default gives all segments off)
DigSel  out  NDIG  anode select, active-low, one-hot-zero
FrameTick  out  1  one-cycle pulse when a new frame becomes visible

Behaviour:
- State registers:
  - pcnt: prescaler, 0..PRESCALE-1
  - idx: current digit, 0..NDIG-1
  - dcnt: dead-time counter
  - pend and pend_v: pending buffer and its valid flag
  - disp: displayed frame
  - FrameTick: registered
- BcdOut and DigSel are combinational decodes of registered state (no extra latency).
- Reset (sampled high), next cycle state:
  - pcnt=0, idx=0, dcnt=0, pend=0, pend_v=0, disp=0, FrameTick=0.
  - With Enable=1 this gives DigSel = all 1 except bit0 = 0, and BcdOut=0.
  - Reset overrides Load, Enable and any slot in progress.
- Prescaler:
  - While Enable=1, pcnt increments every cycle.
  - tick = (pcnt==PRESCALE-1); on tick, pcnt returns to 0.
  - While Enable=0, pcnt, idx and dcnt hold.
- Slot advance on tick:
  - idx advances to idx+1, wrapping NDIG-1 -> 0.
  - dcnt loads DEAD.
  - While dcnt != 0, dcnt decrements and DigSel = all 1 (dark).
  - Once dcnt == 0, DigSel[idx] = 0 and all other bits = 1.
- Output gating:
  - Enable=0 forces DigSel = all 1 and BcdOut = 4'hF.
  - During dead time, BcdOut = 4'hF.
- Load:
  - Load=1 sets pend <= BcdIn and pend_v <= 1 on that edge.
  - Repeated Loads before a frame boundary overwrite pend (last one wins).
- Frame swap on a tick with idx==NDIG-1 (wrap to digit 0), if pend_v was 1 before the edge:
  - disp <= pend (the pre-edge value), pend_v <= 0, FrameTick=1 for exactly one cycle.
  - If Load is also high that cycle: disp takes the old pend; pend takes BcdIn and pend_v stays 1, so the new data shows at the next frame.
  - No tearing: disp changes only at a frame boundary.
- Leading-zero blanking:
  - Digit k (k >= 1) is blanked (BcdOut = 4'hF while selected) iff BlankLZ=1 and disp digits NDIG-1..k are all 0.
  - Digit 0 is never blanked.
  - BlankLZ acts combinationally with no frame sync.
- Invalid BCD in disp (A..F) is passed through unchanged; the decoder blanks it.
- Width rules:
  - pcnt width = clog2(PRESCALE); dcnt width = clog2(DEAD+1), min 1.
  - All counters wrap only as stated; no overflow.

Test Plan:
(Bench parameters: NDIG=4, PRESCALE=4, DEAD=1.)
- Reset then Enable=1, no Load -> DigSel=1110, BcdOut=0. Every 4 cycles: one dark cycle (DigSel=1111, BcdOut=F), then DigSel cycles 1101, 1011, 0111, 1110. FrameTick stays 0.
- Load BcdIn=16'h1234 mid-frame -> disp unchanged until the wrap tick. Then FrameTick pulses once, and the digit 0..3 slots show BcdOut 4, 3, 2, 1.
- Load 16'h1111, then 16'h2222 in the same frame -> only 2222 is displayed. Exactly one FrameTick.
- Load on the exact cycle of the wrap tick, with pend=16'h5678 pending -> 5678 shown now, new value shown one frame later. Two FrameTicks total.
- BlankLZ=1, disp=16'h0050 -> digits 3 and 2 get BcdOut=F, digit 1 gets 5, digit 0 gets 0. With disp=16'h0000, only digit 0 shows 0.
- Enable=0 mid-slot for 10 cycles -> DigSel=1111, BcdOut=F, pcnt/idx frozen; resumes at the same slot position. Reset asserted mid-dead-time -> state returns to idx=0, disp=0 with no FrameTick.
